// File: rtl/player_ctrl_pkg.sv
// Shared game constants and the player FSM state encoding used by the
// player controller and its helpers.
package player_ctrl_pkg;

    localparam int COLS          = 20;
    localparam int ROWS          = 15;
    localparam int SHIP_ROW      = 14;
    localparam int SHIP_HOME     = 5;
    localparam int MISSILE_START = 13;

    localparam logic [1:0] ST_RESPAWN   = 2'd0;
    localparam logic [1:0] ST_ALIVE     = 2'd1;
    localparam logic [1:0] ST_DYING     = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    typedef enum logic [1:0] {
        RESPAWN   = ST_RESPAWN,
        ALIVE     = ST_ALIVE,
        DYING     = ST_DYING,
        GAME_OVER = ST_GAME_OVER
    } state_t;

endpackage

// File: rtl/player_ctrl_tick_div.sv
// Frame-tick divider: strobes on every N-th tick. A clear restarts the count,
// and a tick arriving with the clear is counted as the first tick after it.
module tick_div #(
    parameter int N = 8,
    parameter int W = $clog2(N + 1)
) (
    input  logic dclk,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic strobe
);

    logic [W-1:0] cnt;
    logic [W-1:0] base;

    always_comb begin
        base   = clr ? '0 : cnt;
        strobe = tick && (base == W'(N - 1));
    end

    always_ff @(posedge dclk) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= strobe ? '0 : base + W'(1);
        else
            cnt <= base;
    end

endmodule

// File: rtl/player_ctrl.sv
// Player ship/missile sequencer: rate-limited ship moves, the single player
// missile, and the lives / death / respawn / game-over state machine.
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int MOVE_DIV    = 8,
    parameter int SHOT_DIV    = 2,
    parameter int NUM_LIVES   = 3,
    parameter int EXPLODE_TKS = 16
) (
    input  logic       dclk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic [4:0] posH,
    input  logic       ship_hit,
    input  logic       missile_hit,
    output logic       ship_left,
    output logic       ship_right,
    output logic       ship_enable,
    output logic       ship_clr,
    output logic       missile_on,
    output logic [4:0] missile_col,
    output logic [3:0] missile_row,
    output logic       score_inc,
    output logic [1:0] lives,
    output logic       exploding,
    output logic       game_over
);

    localparam int DW = $clog2(EXPLODE_TKS + 1);

    state_t         state, state_n;
    logic [1:0]     lives_n;
    logic           missile_on_n;
    logic [3:0]     missile_row_n;
    logic [4:0]     missile_col_n;
    logic           score_n;
    logic [DW-1:0]  die_cnt, die_cnt_n, die_sum;
    logic           fire_q, fire_rise, fire_accept;
    logic           alive;
    logic           move_strobe, shot_strobe;

    assign alive       = (state == ALIVE);
    assign fire_rise   = btn_fire && !fire_q;
    assign fire_accept = alive && fire_rise && !missile_on && !ship_hit;

    tick_div #(.N(MOVE_DIV)) u_move_div (
        .dclk   (dclk),
        .reset  (reset),
        .clr    (!alive),
        .tick   (tick),
        .strobe (move_strobe)
    );

    tick_div #(.N(SHOT_DIV)) u_shot_div (
        .dclk   (dclk),
        .reset  (reset),
        .clr    ((state == RESPAWN) || fire_accept),
        .tick   (tick),
        .strobe (shot_strobe)
    );

    always_ff @(posedge dclk) begin
        if (reset)
            state <= RESPAWN;
        else
            state <= state_n;
    end

    // Outside DYING the explosion counter is preloaded so an entry-edge tick counts.
    always_comb begin
        state_n       = state;
        lives_n       = lives;
        missile_on_n  = missile_on;
        missile_row_n = missile_row;
        missile_col_n = missile_col;
        score_n       = 1'b0;
        die_sum       = die_cnt + DW'(tick);
        die_cnt_n     = tick ? DW'(1) : '0;

        unique case (state)
            RESPAWN: state_n = ALIVE;
            ALIVE: begin
                if (ship_hit) begin
                    state_n = DYING;
                    lives_n = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                end
            end
            DYING: begin
                die_cnt_n = die_sum;
                if (die_sum >= DW'(EXPLODE_TKS))
                    state_n = (lives == 2'd0) ? GAME_OVER : RESPAWN;
            end
            GAME_OVER: begin
                if (fire_rise) begin
                    lives_n = 2'(NUM_LIVES);
                    state_n = RESPAWN;
                end
            end
            default: state_n = RESPAWN;
        endcase

        // A hit outranks a same-cycle row step, so the row is left where it was.
        if (missile_on) begin
            if (missile_hit) begin
                missile_on_n = 1'b0;
                score_n      = 1'b1;
            end else if (shot_strobe) begin
                if (missile_row == 4'd0)
                    missile_on_n = 1'b0;
                else
                    missile_row_n = missile_row - 4'd1;
            end
        end else if (fire_accept) begin
            missile_on_n  = 1'b1;
            missile_row_n = 4'(MISSILE_START);
            missile_col_n = posH;
        end

        if (alive && ship_hit)
            missile_on_n = 1'b0;
    end

    always_ff @(posedge dclk) begin
        if (reset) begin
            lives       <= 2'(NUM_LIVES);
            missile_on  <= 1'b0;
            missile_row <= 4'd0;
            missile_col <= 5'd0;
            score_inc   <= 1'b0;
            die_cnt     <= '0;
            fire_q      <= 1'b0;
            ship_clr    <= 1'b0;
            ship_enable <= 1'b0;
            ship_left   <= 1'b0;
            ship_right  <= 1'b0;
            exploding   <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            lives       <= lives_n;
            missile_on  <= missile_on_n;
            missile_row <= missile_row_n;
            missile_col <= missile_col_n;
            score_inc   <= score_n;
            die_cnt     <= die_cnt_n;
            fire_q      <= btn_fire;
            ship_clr    <= (state_n != RESPAWN);
            ship_enable <= alive && move_strobe;
            ship_left   <= alive && btn_left && !btn_right;
            ship_right  <= alive && btn_right && !btn_left;
            exploding   <= (state_n == DYING);
            game_over   <= (state_n == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with default parameters
// (MOVE_DIV=8, SHOT_DIV=2, NUM_LIVES=3, EXPLODE_TKS=16).
module tb_player_ctrl;

    logic       dclk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_fire = 1'b0;
    logic [4:0] posH = 5'd0;
    logic       ship_hit = 1'b0;
    logic       missile_hit = 1'b0;
    logic       ship_left, ship_right, ship_enable, ship_clr;
    logic       missile_on;
    logic [4:0] missile_col;
    logic [3:0] missile_row;
    logic       score_inc;
    logic [1:0] lives;
    logic       exploding, game_over;

    int checks = 0;
    int errors = 0;
    int strobes;

    player_ctrl dut (
        .dclk        (dclk),
        .reset       (reset),
        .tick        (tick),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_fire    (btn_fire),
        .posH        (posH),
        .ship_hit    (ship_hit),
        .missile_hit (missile_hit),
        .ship_left   (ship_left),
        .ship_right  (ship_right),
        .ship_enable (ship_enable),
        .ship_clr    (ship_clr),
        .missile_on  (missile_on),
        .missile_col (missile_col),
        .missile_row (missile_row),
        .score_inc   (score_inc),
        .lives       (lives),
        .exploding   (exploding),
        .game_over   (game_over)
    );

    always #5 dclk = ~dclk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge dclk);
        #1;
    endtask

    task automatic doTick();
        tick = 1'b1;
        applyStimulus();
        tick = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
    endtask

    initial begin
        // Reset and respawn pulse
        doReset();
        checkOutput("rst_clr_low", ship_clr, 0);
        checkOutput("rst_lives", lives, 3);
        checkOutput("rst_missile", missile_on, 0);
        checkOutput("rst_gameover", game_over, 0);
        checkOutput("rst_exploding", exploding, 0);
        checkOutput("rst_row", missile_row, 0);
        applyStimulus();
        checkOutput("alive_clr_high", ship_clr, 1);

        // Movement rate and direction decoding
        btn_left = 1'b1;
        strobes = 0;
        for (int i = 0; i < 32; i++) begin
            doTick();
            if (ship_enable && ship_left) strobes++;
        end
        checkOutput("move_strobes", 8'(strobes), 4);
        btn_right = 1'b1;
        applyStimulus();
        checkOutput("both_left", ship_left, 0);
        checkOutput("both_right", ship_right, 0);
        btn_left = 1'b0;
        applyStimulus();
        checkOutput("right_only", ship_right, 1);
        btn_right = 1'b0;

        // Missile launch, flight, no auto-repeat, re-fire ignored
        doReset();
        applyStimulus();
        posH = 5'd7;
        btn_fire = 1'b1;
        applyStimulus();
        checkOutput("fire_on", missile_on, 1);
        checkOutput("fire_col", missile_col, 7);
        checkOutput("fire_row", missile_row, 13);
        for (int i = 0; i < 10; i++) doTick();
        checkOutput("row_after10", missile_row, 8);
        btn_fire = 1'b0;
        posH = 5'd3;
        applyStimulus();
        btn_fire = 1'b1;
        applyStimulus();
        btn_fire = 1'b0;
        checkOutput("refire_row", missile_row, 8);
        checkOutput("refire_col", missile_col, 7);
        for (int i = 0; i < 16; i++) doTick();
        checkOutput("row_top", missile_row, 0);
        checkOutput("on_at_top", missile_on, 1);
        doTick();
        doTick();
        checkOutput("off_past_top", missile_on, 0);

        // Hit wins over a coincident step; stray hit ignored
        doReset();
        applyStimulus();
        btn_fire = 1'b1;
        applyStimulus();
        btn_fire = 1'b0;
        for (int i = 0; i < 15; i++) doTick();
        checkOutput("row_six", missile_row, 6);
        tick = 1'b1;
        missile_hit = 1'b1;
        applyStimulus();
        tick = 1'b0;
        missile_hit = 1'b0;
        checkOutput("hit_off", missile_on, 0);
        checkOutput("hit_score", score_inc, 1);
        checkOutput("hit_row_kept", missile_row, 6);
        applyStimulus();
        checkOutput("score_one_cycle", score_inc, 0);
        missile_hit = 1'b1;
        applyStimulus();
        missile_hit = 1'b0;
        checkOutput("stray_hit", score_inc, 0);

        // Deaths down to game over
        doReset();
        applyStimulus();
        ship_hit = 1'b1;
        applyStimulus();
        ship_hit = 1'b0;
        checkOutput("die1_lives", lives, 2);
        checkOutput("die1_exploding", exploding, 1);
        for (int i = 0; i < 16; i++) doTick();
        checkOutput("die1_respawn", ship_clr, 0);
        checkOutput("die1_not_exploding", exploding, 0);
        applyStimulus();
        ship_hit = 1'b1;
        applyStimulus();
        ship_hit = 1'b0;
        checkOutput("die2_lives", lives, 1);
        for (int i = 0; i < 16; i++) doTick();
        applyStimulus();
        btn_fire = 1'b1;
        applyStimulus();
        btn_fire = 1'b0;
        checkOutput("last_fire_on", missile_on, 1);
        ship_hit = 1'b1;
        applyStimulus();
        ship_hit = 1'b0;
        checkOutput("die3_missile", missile_on, 0);
        checkOutput("die3_lives", lives, 0);
        checkOutput("die3_exploding", exploding, 1);
        btn_left = 1'b1;
        strobes = 0;
        for (int i = 0; i < 15; i++) begin
            doTick();
            if (ship_enable) strobes++;
        end
        checkOutput("still_exploding", exploding, 1);
        checkOutput("not_over_yet", game_over, 0);
        doTick();
        if (ship_enable) strobes++;
        checkOutput("game_over", game_over, 1);
        checkOutput("over_not_exploding", exploding, 0);
        for (int i = 0; i < 16; i++) begin
            doTick();
            if (ship_enable) strobes++;
        end
        checkOutput("no_moves_dead", 8'(strobes), 0);
        checkOutput("over_held", game_over, 1);
        btn_left = 1'b0;

        // Restart from game over
        btn_fire = 1'b1;
        applyStimulus();
        btn_fire = 1'b0;
        checkOutput("restart_lives", lives, 3);
        checkOutput("restart_clr_low", ship_clr, 0);
        checkOutput("restart_over_clear", game_over, 0);
        applyStimulus();
        checkOutput("restart_clr_high", ship_clr, 1);

        // Reset in the middle of DYING
        ship_hit = 1'b1;
        applyStimulus();
        ship_hit = 1'b0;
        for (int i = 0; i < 5; i++) doTick();
        checkOutput("mid_dying", exploding, 1);
        reset = 1'b1;
        applyStimulus();
        checkOutput("rst_dying_exploding", exploding, 0);
        checkOutput("rst_dying_lives", lives, 3);
        checkOutput("rst_dying_clr", ship_clr, 0);
        checkOutput("rst_dying_missile", missile_on, 0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("rst_dying_alive", ship_clr, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
